vector_mac_param: RTL and testbench
===================================

# vector_mac_param

Parametrised successor to `vector_mac_top`: a pipelined LANES-wide integer dot-product engine with a programmable accumulation window.
- Generalises lane count, element width and accumulator width.
- Adds signed/unsigned mode, early window close via `in_last`, and valid/ready backpressure on both sides.
- Sits between the operand streamer and the result FIFO in the MAC datapath.

## Interface
- LANES, 4, number of element pairs per beat; power of two, 1–32
- DATA_W, 8, element width in bits
- ACC_W, 32, accumulator/result width; must be ≥ 2*DATA_W+clog2(LANES)
- CNT_W, 16, width of window-length and beat-count fields
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- cfg_signed  in  1  1 = two's-complement elements, 0 = unsigned
- cfg_beats  in  CNT_W  window length in beats; 0 treated as 1
- in_valid  in  1  operand beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_a  in  LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W]
- in_b  in  LANES*DATA_W  same packing as in_a
- in_last  in  1  closes the window on this beat regardless of count
- out_valid  out  1  result held valid
- out_ready  in  1  result consumed when out_valid && out_ready
- mac_out  out  ACC_W  window sum, two's complement when signed
- out_count  out  CNT_W  beats accumulated in this window
- out_ovf  out  1  accumulator overflow occurred in window

## Operation
- Pipeline stages:
  - S1: input register.
  - S2: LANES products, each 2*DATA_W bits, signed or unsigned per mode.
  - S3..S(2+T): binary adder tree, T = clog2(LANES) registered levels, sign/zero-extended one bit per level.
  - SA: accumulator.
  - SO: output register.
- Mode flags ride the pipeline with each beat: valid, last, signed.
- cfg_signed and cfg_beats are latched on the first accepted beat of each window. Mid-window changes are ignored.
- Window counter counts beats reaching SA. A beat closes the window when counter == latched_beats−1 or its last flag is set.
- On a closing beat:
  - SO loads acc+sum, out_count = counter+1, ovf flag.
  - acc, counter and ovf clear in the same cycle.
  - The next beat starts a new window with no dead cycle.
- Extension of the tree sum to ACC_W: sign-extend if signed, else zero-extend.
- Global stall `stall = out_valid && !out_ready`:
  - All stages freeze while stall is high.
  - in_ready = !stall.
  - No beat is dropped or duplicated.
- out_valid falls on the handshake cycle unless a new closing beat loads SO in that same cycle, in which case it stays high with the new data.
- Reset mid-operation: the partial window and all in-flight beats are discarded.
- Reset values: out_valid=0, mac_out=0, out_count=0, out_ovf=0, in_ready=1; all internal stages and counters cleared.

## Timing
- Latency LAT = 4+clog2(LANES): 6 cycles at LANES=4.
  - A closing beat accepted at edge t produces out_valid=1 after edge t+LAT−1, sampled at edge t+LAT.
  - Stall cycles add one cycle each.
- Throughput: one beat per cycle when out_ready is held high.
- Minimum window of 1 beat gives back-to-back out_valid every cycle.
- in_ready is combinational from out_valid/out_ready only; there is no path from in_valid.
- While stalled, mac_out, out_count and out_ovf are stable.
- Async reset takes effect immediately; release is synchronised externally.

## Configuration
- Macro: VMAC_SAT_EN.
- Defined:
  - The accumulator saturates: unsigned clamps at 2^ACC_W−1; signed clamps at 2^(ACC_W−1)−1 / −2^(ACC_W−1).
  - out_ovf is the sticky flag for the window.
  - Once saturated, the value stays clamped for the rest of the window.
- Undefined:
  - The accumulator wraps modulo 2^ACC_W.
  - out_ovf is tied to 0 and no saturation logic is synthesised.

## Test plan
- Unsigned, defaults, cfg_beats=250, 250 beats of a=b=0xFFFFFFFF -> one result mac_out=65,025,000, out_count=250, out_ovf=0, out_valid 6 cycles after the last beat.
- Signed, cfg_beats=4, a=0x80808080, b=0x7F7F7F7F ×4 -> mac_out=0xFFFC0800 (−260,096), out_count=4.
- cfg_beats=250, a=b=0x01010101, in_last on 3rd beat, then 250 further beats -> mac_out=12, out_count=3; next result 1000, out_count=250.
- out_ready low for 10 cycles while out_valid, in_valid held high with random data -> in_ready=0 throughout, mac_out stable, every random window matches the golden model with no lost beat.
- ACC_W=20, unsigned, cfg_beats=5, a=b=0xFFFFFFFF:
  - VMAC_SAT_EN defined -> mac_out=1,048,575, out_ovf=1.
  - VMAC_SAT_EN undefined -> mac_out=251,924, out_ovf=0.
- rst_n pulsed low after 100 of 250 beats, then 250 beats of a=b=0x01010101 -> out_valid=0 during reset, no stale output, next result 1000.

Source files
------------

// File: rtl/vector_mac_param_if.sv
// Operand/result stream bundle for vector_mac_param.
// The master side drives operands, config and out_ready; the slave side is the MAC engine.
interface vector_mac_param_if #(
  parameter int LANES  = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 16
) ();
  logic                      cfg_signed;
  logic [CNT_W-1:0]          cfg_beats;
  logic                      in_valid;
  logic                      in_ready;
  logic [LANES*DATA_W-1:0]   in_a;
  logic [LANES*DATA_W-1:0]   in_b;
  logic                      in_last;
  logic                      out_valid;
  logic                      out_ready;
  logic [ACC_W-1:0]          mac_out;
  logic [CNT_W-1:0]          out_count;
  logic                      out_ovf;

  modport master (
    output cfg_signed, cfg_beats, in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, mac_out, out_count, out_ovf
  );

  modport slave (
    input  cfg_signed, cfg_beats, in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, mac_out, out_count, out_ovf
  );
endinterface

// File: rtl/vector_mac_param.sv
// Pipelined LANES-wide dot-product engine with a programmable accumulation window.
// Define VMAC_SAT_EN for a saturating accumulator with a sticky overflow flag; otherwise it wraps.
module vector_mac_param #(
  parameter int LANES  = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  vector_mac_param_if.slave   bus
);
  localparam int T  = $clog2(LANES);
  localparam int PW = 2 * DATA_W;
  localparam int TW = PW + T;

  function automatic logic [TW-1:0] lane_mul(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                             input logic sgn);
    logic signed [DATA_W:0] ea;
    logic signed [DATA_W:0] eb;
    logic signed [PW+1:0]   pr;
    ea = signed'({sgn & a[DATA_W-1], a});
    eb = signed'({sgn & b[DATA_W-1], b});
    pr = ea * eb;
    return TW'(pr);
  endfunction

  function automatic logic [ACC_W-1:0] ext_sum(input logic [TW-1:0] s, input logic sgn);
    logic [ACC_W-1:0] r;
    if (sgn) r = ACC_W'(signed'(s));
    else     r = ACC_W'(s);
    return r;
  endfunction

  logic r_out_valid;
  logic w_en, w_acc_in;
  assign w_en         = !(r_out_valid && !bus.out_ready);
  assign bus.in_ready = w_en;
  assign w_acc_in     = bus.in_valid && w_en;

  // Window bookkeeping at the input: config latched on a window's first beat, closing flag rides the beat
  logic             r_first, r_sgn_lat;
  logic [CNT_W-1:0] r_in_cnt, r_beats;
  logic [CNT_W-1:0] w_beats_cur, w_cnt_cur;
  logic             w_sgn_cur, w_close_in;

  always_comb begin
    w_beats_cur = r_beats;
    w_cnt_cur   = r_in_cnt;
    w_sgn_cur   = r_sgn_lat;
    if (r_first) begin
      w_beats_cur = (bus.cfg_beats == '0) ? CNT_W'(1) : bus.cfg_beats;
      w_cnt_cur   = '0;
      w_sgn_cur   = bus.cfg_signed;
    end
    w_close_in = bus.in_last || (w_cnt_cur == w_beats_cur - CNT_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_first   <= 1'b1;
      r_in_cnt  <= '0;
      r_beats   <= '0;
      r_sgn_lat <= 1'b0;
    end else if (w_acc_in) begin
      r_first   <= w_close_in;
      r_in_cnt  <= w_close_in ? '0 : w_cnt_cur + CNT_W'(1);
      r_beats   <= w_beats_cur;
      r_sgn_lat <= w_sgn_cur;
    end
  end

  // S1: input register
  logic [LANES*DATA_W-1:0] r_a_p0, r_b_p0;
  logic                    r_vld_p0, r_last_p0, r_sgn_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_p0    <= '0;
      r_b_p0    <= '0;
      r_vld_p0  <= 1'b0;
      r_last_p0 <= 1'b0;
      r_sgn_p0  <= 1'b0;
    end else if (w_en) begin
      r_a_p0    <= bus.in_a;
      r_b_p0    <= bus.in_b;
      r_vld_p0  <= bus.in_valid;
      r_last_p0 <= w_close_in;
      r_sgn_p0  <= w_sgn_cur;
    end
  end

  // S2 and adder tree: level 0 holds the products, level l holds LANES>>l partial sums
  logic [TW-1:0] r_tree_p1 [T+1][LANES];
  logic [T:0]    r_vld_p1, r_last_p1, r_sgn_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l <= T; l++)
        for (int j = 0; j < LANES; j++) r_tree_p1[l][j] <= '0;
      r_vld_p1  <= '0;
      r_last_p1 <= '0;
      r_sgn_p1  <= '0;
    end else if (w_en) begin
      for (int j = 0; j < LANES; j++)
        r_tree_p1[0][j] <= lane_mul(r_a_p0[j*DATA_W +: DATA_W], r_b_p0[j*DATA_W +: DATA_W], r_sgn_p0);
      r_vld_p1[0]  <= r_vld_p0;
      r_last_p1[0] <= r_last_p0;
      r_sgn_p1[0]  <= r_sgn_p0;
      for (int l = 1; l <= T; l++) begin
        for (int j = 0; j < LANES / 2; j++)
          if (j < (LANES >> l)) r_tree_p1[l][j] <= r_tree_p1[l-1][2*j] + r_tree_p1[l-1][2*j+1];
        r_vld_p1[l]  <= r_vld_p1[l-1];
        r_last_p1[l] <= r_last_p1[l-1];
        r_sgn_p1[l]  <= r_sgn_p1[l-1];
      end
    end
  end

  // SA: tree sum extended to accumulator width
  logic [ACC_W-1:0] r_sum_p2;
  logic             r_vld_p2, r_last_p2;
`ifdef VMAC_SAT_EN
  logic             r_sgn_p2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum_p2  <= '0;
      r_vld_p2  <= 1'b0;
      r_last_p2 <= 1'b0;
`ifdef VMAC_SAT_EN
      r_sgn_p2  <= 1'b0;
`endif
    end else if (w_en) begin
      r_sum_p2  <= ext_sum(r_tree_p1[T][0], r_sgn_p1[T]);
      r_vld_p2  <= r_vld_p1[T];
      r_last_p2 <= r_last_p1[T];
`ifdef VMAC_SAT_EN
      r_sgn_p2  <= r_sgn_p1[T];
`endif
    end
  end

  logic [ACC_W-1:0] r_acc, r_mac, w_acc_nxt;
  logic [CNT_W-1:0] r_cnt, r_out_cnt;

`ifdef VMAC_SAT_EN
  logic r_ovf, r_out_ovf, w_ovf_nxt;

  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] acc, input logic [ACC_W-1:0] add,
                                             input logic sgn);
    logic [ACC_W:0]   s;
    logic [ACC_W-1:0] v;
    logic             ovf;
    if (sgn) begin
      s   = {acc[ACC_W-1], acc} + {add[ACC_W-1], add};
      ovf = s[ACC_W] ^ s[ACC_W-1];
      v   = !ovf ? s[ACC_W-1:0] : (s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}});
    end else begin
      s   = {1'b0, acc} + {1'b0, add};
      ovf = s[ACC_W];
      v   = ovf ? '1 : s[ACC_W-1:0];
    end
    return {ovf, v};
  endfunction

  // A clamped window holds its clamp value until it closes
  always_comb begin
    {w_ovf_nxt, w_acc_nxt} = sat_add(r_acc, r_sum_p2, r_sgn_p2);
    if (r_ovf) {w_ovf_nxt, w_acc_nxt} = {1'b1, r_acc};
  end
  assign bus.out_ovf = r_out_ovf;
`else
  assign w_acc_nxt   = r_acc + r_sum_p2;
  assign bus.out_ovf = 1'b0;
`endif

  // SO: accumulator update and result register; a closing beat loads SO and restarts the window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_mac       <= '0;
      r_out_cnt   <= '0;
      r_out_valid <= 1'b0;
`ifdef VMAC_SAT_EN
      r_ovf       <= 1'b0;
      r_out_ovf   <= 1'b0;
`endif
    end else if (w_en) begin
      r_out_valid <= r_vld_p2 && r_last_p2;
      if (r_vld_p2) begin
        if (r_last_p2) begin
          r_mac     <= w_acc_nxt;
          r_out_cnt <= r_cnt + CNT_W'(1);
          r_acc     <= '0;
          r_cnt     <= '0;
`ifdef VMAC_SAT_EN
          r_out_ovf <= w_ovf_nxt;
          r_ovf     <= 1'b0;
`endif
        end else begin
          r_acc     <= w_acc_nxt;
          r_cnt     <= r_cnt + CNT_W'(1);
`ifdef VMAC_SAT_EN
          r_ovf     <= w_ovf_nxt;
`endif
        end
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.mac_out   = r_mac;
  assign bus.out_count = r_out_cnt;
endmodule

// File: tb/tb_vector_mac_param.sv
// Directed bench for vector_mac_param: a behavioural window model fills a scoreboard at
// acceptance time; a monitor pops and compares on every result handshake.
module tb_vector_mac_param;
  localparam int LANES  = 4;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 32;
  localparam int CNT_W  = 16;
  localparam int LAT    = 4 + $clog2(LANES);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vector_mac_param_if #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();
  vector_mac_param #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  vector_mac_param_if #(.LANES(4), .DATA_W(8), .ACC_W(20), .CNT_W(16)) bus2 ();
  vector_mac_param #(.LANES(4), .DATA_W(8), .ACC_W(20), .CNT_W(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2));

  typedef struct packed {
    logic [63:0] mac;
    logic [63:0] cnt;
    logic        ovf;
  } res_t;

  res_t    sb[$];
  int      n_vec = 0;
  int      n_bad = 0;

  bit      m_first = 1'b1;
  bit      m_sgn   = 1'b0;
  int      m_cnt   = 0;
  int      m_beats = 1;
  longint  m_acc   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint dot(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    longint s = 0;
    logic [7:0] ea, eb;
    for (int i = 0; i < LANES; i++) begin
      ea = a[i*8 +: 8];
      eb = b[i*8 +: 8];
      if (sgn) s += longint'($signed(ea)) * longint'($signed(eb));
      else     s += longint'(ea) * longint'(eb);
    end
    return s;
  endfunction

  task automatic model_accept(input logic [31:0] a, input logic [31:0] b, input bit last);
    res_t r;
    if (m_first) begin
      m_beats = (bus.cfg_beats == 0) ? 1 : int'(bus.cfg_beats);
      m_sgn   = bus.cfg_signed;
      m_cnt   = 0;
      m_acc   = 0;
      m_first = 1'b0;
    end
    m_acc += dot(a, b, m_sgn);
    m_cnt++;
    if (last || m_cnt == m_beats) begin
      r.mac = {32'h0, m_acc[31:0]};
      r.cnt = 64'(m_cnt);
      r.ovf = 1'b0;
      sb.push_back(r);
      m_first = 1'b1;
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input bit last);
    bit rdy;
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_last  = last;
    do begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 1000);
    if (rdy) model_accept(a, b, last);
    else chk("in_ready_timeout", 64'(rdy), 64'(1));
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("drain_pending", 64'(sb.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      res_t e;
      n_vec++;
      assert (sb.size() != 0) else begin
        n_bad++;
        $error("FAIL unexpected_result: observed mac_out=%0d with no result expected", bus.mac_out);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("mac_out",   64'(bus.mac_out),   e.mac);
        chk("out_count", 64'(bus.out_count), e.cnt);
        chk("out_ovf",   64'(bus.out_ovf),   64'(e.ovf));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hold_mac;
    logic [15:0] hold_cnt;
    int          n;
    bus.cfg_signed = 1'b0; bus.cfg_beats = 16'd1; bus.in_valid = 1'b0; bus.in_last = 1'b0;
    bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b1;
    bus2.cfg_signed = 1'b0; bus2.cfg_beats = 16'd5; bus2.in_valid = 1'b0; bus2.in_last = 1'b0;
    bus2.in_a = '0; bus2.in_b = '0; bus2.out_ready = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_mac_out",   64'(bus.mac_out),   64'(0));
    chk("rst_out_count", 64'(bus.out_count), 64'(0));
    chk("rst_out_ovf",   64'(bus.out_ovf),   64'(0));
    chk("rst_in_ready",  64'(bus.in_ready),  64'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // unsigned all-ones window of 250 beats, plus result latency
    bus.cfg_signed = 1'b0; bus.cfg_beats = 16'd250;
    for (int i = 0; i < 250; i++) send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 20);
    chk("latency", 64'(n), 64'(LAT));
    chk("test1_mac", 64'(bus.mac_out), 64'(65025000));
    drain();

    // signed extreme operands
    bus.cfg_signed = 1'b1; bus.cfg_beats = 16'd4;
    for (int i = 0; i < 4; i++) send(32'h8080_8080, 32'h7F7F_7F7F, 1'b0);
    drain();

    // early close via in_last, then a full window
    bus.cfg_signed = 1'b0; bus.cfg_beats = 16'd250;
    for (int i = 0; i < 3; i++) send(32'h0101_0101, 32'h0101_0101, i == 2);
    for (int i = 0; i < 250; i++) send(32'h0101_0101, 32'h0101_0101, 1'b0);
    drain();

    // cfg_beats=0 behaves as single-beat windows
    bus.cfg_signed = 1'b1; bus.cfg_beats = 16'd0;
    for (int i = 0; i < 6; i++) send($urandom, $urandom, 1'b0);
    drain();

    // output backpressure with random data
    bus.cfg_signed = 1'b1; bus.cfg_beats = 16'd3;
    fork
      begin
        for (int i = 0; i < 30; i++) send($urandom, $urandom, 1'b0);
      end
      begin
        bus.out_ready = 1'b0;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!bus.out_valid && n < 100);
        chk("stall_out_valid", 64'(bus.out_valid), 64'(1));
        hold_mac = bus.mac_out;
        hold_cnt = bus.out_count;
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          chk("stall_in_ready",  64'(bus.in_ready),  64'(0));
          chk("stall_mac_out",   64'(bus.mac_out),   64'(hold_mac));
          chk("stall_out_count", 64'(bus.out_count), 64'(hold_cnt));
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // reset in the middle of a window
    bus.cfg_signed = 1'b0; bus.cfg_beats = 16'd250;
    for (int i = 0; i < 100; i++) send(32'h0101_0101, 32'h0101_0101, 1'b0);
    rst_n   = 1'b0;
    m_first = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
      chk("mid_rst_in_ready",  64'(bus.in_ready),  64'(1));
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 250; i++) send(32'h0101_0101, 32'h0101_0101, 1'b0);
    drain();

    // narrow accumulator: wrap or saturate
    for (int i = 0; i < 5; i++) begin
      bus2.in_valid = 1'b1; bus2.in_a = 32'hFFFF_FFFF; bus2.in_b = 32'hFFFF_FFFF;
      @(posedge clk); #1;
    end
    bus2.in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus2.out_valid && n < 20);
    chk("acc20_out_valid", 64'(bus2.out_valid), 64'(1));
    chk("acc20_out_count", 64'(bus2.out_count), 64'(5));
`ifdef VMAC_SAT_EN
    chk("acc20_mac_out", 64'(bus2.mac_out), 64'(1048575));
    chk("acc20_out_ovf", 64'(bus2.out_ovf), 64'(1));
`else
    chk("acc20_mac_out", 64'(bus2.mac_out), 64'(251924));
    chk("acc20_out_ovf", 64'(bus2.out_ovf), 64'(0));
`endif
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
